// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width, state and
// fault-cause encodings, and the reset instruction.
package inst_fetch_pkg;

  localparam int CPU_WIDTH = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_BUS      = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } fault_cause_e;

  function automatic logic pc_misaligned(input logic [CPU_WIDTH-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_timer.sv
// Clearable saturating cycle counter; expired is high once the count reaches
// TIMEOUT_CYCLES-1, i.e. in the last cycle the awaited event may still occur.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding read to instruction memory, holds the
// fetched word until the core acks it, and latches a sticky fault on error.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPU_WIDTH-1:0] pc_i,
  input  logic                 fetch_en,
  input  logic                 flush,
  input  logic                 inst_ack,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [CPU_WIDTH-1:0] mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [31:0]          mem_rsp_data,
  input  logic                 mem_rsp_err,
  output logic [31:0]          inst_o,
  output logic                 inst_valid,
  output logic                 fault,
  output logic [1:0]           fault_cause
);

  fetch_state_e         state_q, state_d;
  logic                 req_valid_q, req_valid_d;
  logic [CPU_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [31:0]          inst_q, inst_d;
  logic                 inst_valid_q, inst_valid_d;
  logic                 fault_q, fault_d;
  logic [1:0]           cause_q, cause_d;
  logic                 timer_clr, timer_inc, timer_expired;
  logic                 req_hs;

  assign req_hs = req_valid_q & mem_req_ready;

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    cause_d    = cause_q;
    timer_clr  = 1'b0;
    timer_inc  = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    case (state_q)
      ST_IDLE: begin
        if (fetch_en) begin
          if (pc_misaligned(pc_i)) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d    = ST_REQ;
            req_addr_d = pc_i;
            timer_clr  = 1'b1;
          end
        end
      end

      ST_REQ: begin
        if (req_hs) begin
          state_d = flush ? ST_DRAIN : ST_WAIT;
        end else if (flush) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      ST_WAIT: begin
        // A response arriving alongside flush is simply dropped; there is
        // nothing left to drain.
        if (mem_rsp_valid) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else if (mem_rsp_err) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_BUS;
          end else begin
            state_d = ST_VALID;
            inst_d  = mem_rsp_data;
          end
        end else if (timer_expired) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end

      ST_VALID: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (inst_ack) begin
          if (!fetch_en) begin
            state_d = ST_IDLE;
          end else if (pc_misaligned(pc_i)) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d    = ST_REQ;
            req_addr_d = pc_i;
            timer_clr  = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (mem_rsp_valid) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      default: begin
        state_d = ST_FAULT;
      end
    endcase

    req_valid_d  = (state_d == ST_REQ);
    inst_valid_d = (state_d == ST_VALID);
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      cause_q      <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign inst_o        = inst_q;
  assign inst_valid    = inst_valid_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit sitting directly upstream of the single-cycle core: takes the current PC from the PC register, fetches the 32-bit instruction from instruction memory over a valid/ready request and valid-only response handshake, and presents it to the decoder/control path held stable until the core acknowledges it. The core's PC-update enable is `inst_valid & inst_ack`. The unit also detects misaligned PCs, bus errors and memory timeouts, and reports them as a sticky fault.

## Interface
- `TIMEOUT_CYCLES`, default 256: cycles allowed from entering REQ to the response before a timeout fault is raised; must be ≥ 2.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_i`  in  `CPU_WIDTH`  current PC from the PC register.
- `fetch_en`  in  1  core requests fetching.
- `flush`  in  1  discard the in-flight or held instruction.
- `inst_ack`  in  1  core consumes `inst_o` this cycle.
- `mem_req_valid`  out  1  instruction-memory read request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  `CPU_WIDTH`  word-aligned read address.
- `mem_rsp_valid`  in  1  read data valid, one cycle pulse.
- `mem_rsp_data`  in  32  instruction word.
- `mem_rsp_err`  in  1  bus error, qualified by `mem_rsp_valid`.
- `inst_o`  out  32  fetched instruction.
- `inst_valid`  out  1  `inst_o` is valid.
- `fault`  out  1  sticky fetch fault.
- `fault_cause`  out  2  01 misaligned, 10 bus error, 11 timeout, 00 none.

## Operation
- States: IDLE, REQ, WAIT, VALID, DRAIN, FAULT. All outputs are registered.
- Reset: state IDLE; `mem_req_valid`=0; `mem_req_addr`=0; `inst_o`=32'h00000013 (NOP); `inst_valid`=0; `fault`=0; `fault_cause`=00; timer=0.
- IDLE:
  - If `fetch_en` and `pc_i[1:0]`≠0, go to FAULT with cause 01; no request is issued.
  - If `fetch_en` with an aligned PC, latch `pc_i` into `mem_req_addr` and go to REQ.
- REQ:
  - `mem_req_valid`=1 and `mem_req_addr` is held constant.
  - On `mem_req_valid & mem_req_ready`, go to WAIT.
- WAIT:
  - On `mem_rsp_valid` with `mem_rsp_err`=0, register `mem_rsp_data` into `inst_o` and go to VALID.
  - On `mem_rsp_valid` with `mem_rsp_err`=1, go to FAULT with cause 10.
- VALID:
  - `inst_valid`=1 and `inst_o` is held.
  - On `inst_ack`, go to REQ (latching the new `pc_i`) if `fetch_en` is high, otherwise to IDLE. The misalignment check applies, as in IDLE.
- Flush:
  - In REQ without a handshake that cycle, go to IDLE. Withdrawing `mem_req_valid` is permitted on this interface.
  - In REQ with a handshake that cycle, or in WAIT, go to DRAIN.
  - In VALID, go to IDLE and drop `inst_valid`. A simultaneous `flush` and `inst_ack` counts as consumed: next state is IDLE.
  - In IDLE, flush has no effect.
- DRAIN: on `mem_rsp_valid`, discard the data (including any error) and go to IDLE. Exactly one outstanding request is drained.
- FAULT:
  - `fault`=1 and `fault_cause` are held; `mem_req_valid`=0, `inst_valid`=0.
  - FAULT is left only by `rst`; `flush` does not clear it.
- Timer:
  - Cleared on every entry to REQ.
  - Increments each cycle in REQ, WAIT and DRAIN; it is not cleared on the REQ→WAIT or WAIT→DRAIN transitions.
  - If the timer equals `TIMEOUT_CYCLES-1` and the awaited event does not occur that cycle, go to FAULT with cause 11. The awaited event is the handshake in REQ and `mem_rsp_valid` in WAIT/DRAIN.
  - Width: clog2(`TIMEOUT_CYCLES`).
- `mem_rsp_valid` in IDLE, REQ, VALID or FAULT is ignored.
- At most one request is outstanding at any time.

## Timing
- Handshake at edge of cycle N (REQ→WAIT).
- Response no earlier than cycle N+1; memory never responds in the handshake cycle.
- Response in cycle R gives `inst_valid`=1 and new `inst_o` in cycle R+1.
- Ack in cycle A: `inst_valid`=0 in A+1, and `mem_req_valid`=1 in A+1 if `fetch_en` was high. `pc_i` is sampled in cycle A, so the core must present the next PC combinationally or the PC register must update at the A edge. Implementer and core owner confirm which convention holds before integration.
- Zero-wait memory throughput: one instruction per 3 cycles (REQ, WAIT, VALID).
- A timeout fault is visible exactly `TIMEOUT_CYCLES` cycles after REQ entry.
- `rst` mid-transaction returns to IDLE next cycle; a late response is then ignored, since IDLE ignores responses.

## Structure
- Shared defines file (`rvseed_defines.v`) holds `CPU_WIDTH`, the state encodings, the `fault_cause` codes and the NOP constant 32'h00000013.
- One natural sub-module: `fetch_timer`, a clearable saturating counter with a compare-to-limit output, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- Zero-wait fetch: `pc_i`=0x80000000, `fetch_en`=1, ready=1, response 1 cycle later with 0x00100093 → `inst_o`=0x00100093 and `inst_valid`=1 in cycle 3; ack → next request issued at 0x80000004.
- Backpressure and latency: ready low for 4 cycles, response 5 cycles after handshake → `mem_req_addr` stable throughout; `inst_valid` rises exactly 1 cycle after the response; no ack for 3 cycles → `inst_o` held.
- Misaligned PC: `pc_i`=0x80000002 → no `mem_req_valid`; `fault`=1, cause 01 next cycle; sticky until `rst`.
- Bus error: response with `mem_rsp_err`=1 → `fault`=1, cause 10; `inst_valid` stays 0.
- Flush in WAIT: response with 0xDEADBEEF arrives 2 cycles later → discarded (`inst_valid` stays 0), state IDLE; a next fetch of 0x00000013 is delivered normally.
- Timeout: `TIMEOUT_CYCLES`=8, request accepted, no response → `fault`=1, cause 11, exactly 8 cycles after REQ entry; `rst` clears it to IDLE with all reset values.
